// File: rtl/wb_clkdiv_multi.sv
// Wishbone-programmable bank of clock-enable dividers, all in the wb_clk_i domain.
// Each channel emits a one-cycle enable pulse and a square wave that toggles on every wrap.
module wb_clkdiv_multi #(
    parameter int          CHANNELS    = 2,
    parameter int          WIDTH       = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          DEFAULT_DIV = 2
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_n,
    input  logic                wbs_stb_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_dat_i,
    input  logic [31:0]         wbs_adr_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    output logic [CHANNELS-1:0] clk_en_o,
    output logic [CHANNELS-1:0] clk_div_o
);

    // per-channel state | meaning
    //   IDLE (en_q=0)   | counter parked at 0, outputs low, active tracks shadow
    //   RUN  (en_q=1)   | counter climbs to active, wraps, pulses, reloads active

    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
    localparam logic [31:0]      SPAN    = 32'(8 * CHANNELS);

    logic                ack_q;
    logic [31:0]         dat_q;
    logic [WIDTH-1:0]    shadow_q [CHANNELS];
    logic [WIDTH-1:0]    active_q [CHANNELS];
    logic [WIDTH-1:0]    cnt_q    [CHANNELS];
    logic [CHANNELS-1:0] en_q;
    logic [CHANNELS-1:0] clk_en_q;
    logic [CHANNELS-1:0] clk_div_q;

    logic                req;
    logic [31:0]         offset;
    logic                in_range;
    logic [31:0]         wmask;
    logic [31:0]         rd_val;
    logic [CHANNELS-1:0] hit;
    logic [WIDTH-1:0]    shadow_d [CHANNELS];
    logic [CHANNELS-1:0] en_d;

    always_comb begin
        req      = wbs_stb_i & wbs_cyc_i & ~ack_q;
        offset   = wbs_adr_i - BASE_ADDR;
        in_range = offset < SPAN;
        for (int b = 0; b < 4; b++) begin
            wmask[8*b +: 8] = {8{wbs_sel_i[b]}};
        end
        rd_val = '0;
        en_d   = en_q;
        for (int c = 0; c < CHANNELS; c++) begin
            hit[c]      = in_range && (offset[31:3] == 29'(c));
            shadow_d[c] = shadow_q[c];
            if (req && wbs_we_i && hit[c]) begin
                if (!offset[2]) begin
                    shadow_d[c] = WIDTH'((32'(shadow_q[c]) & ~wmask) | (wbs_dat_i & wmask));
                end else if (wbs_sel_i[0]) begin
                    en_d[c] = wbs_dat_i[0];
                end
            end
            if (hit[c]) begin
                rd_val = offset[2]
                    ? 32'({cnt_q[c], 14'b0, shadow_q[c] != active_q[c], en_q[c]})
                    : 32'(shadow_q[c]);
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            ack_q     <= 1'b0;
            dat_q     <= '0;
            en_q      <= '1;
            clk_en_q  <= '0;
            clk_div_q <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                shadow_q[c] <= DIV_RST;
                active_q[c] <= DIV_RST;
                cnt_q[c]    <= '0;
            end
        end else begin
            ack_q <= req;
            dat_q <= (req && !wbs_we_i) ? rd_val : '0;
            en_q  <= en_d;
            for (int c = 0; c < CHANNELS; c++) begin
                shadow_q[c] <= shadow_d[c];
                // The old shadow_q is sampled here, so a DIV write landing on a wrap waits one period.
                if (!en_q[c]) begin
                    cnt_q[c]     <= '0;
                    clk_en_q[c]  <= 1'b0;
                    clk_div_q[c] <= 1'b0;
                    active_q[c]  <= shadow_q[c];
                end else if (cnt_q[c] == active_q[c]) begin
                    cnt_q[c]     <= '0;
                    clk_en_q[c]  <= 1'b1;
                    clk_div_q[c] <= ~clk_div_q[c];
                    active_q[c]  <= shadow_q[c];
                end else begin
                    cnt_q[c]     <= cnt_q[c] + WIDTH'(1);
                    clk_en_q[c]  <= 1'b0;
                end
            end
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = ack_q ? dat_q : '0;
    assign clk_en_o  = clk_en_q;
    assign clk_div_o = clk_div_q;

endmodule
